// File: rtl/naive_codec_pkg.sv
// Shared definitions for the naive codec path: ASCII case bounds,
// the byte-holding FSM state encoding and the case-swap function.
package naive_codec_pkg;

  localparam logic [7:0] ASCII_UP_LO = 8'h41;
  localparam logic [7:0] ASCII_UP_HI = 8'h5A;
  localparam logic [7:0] ASCII_LC_LO = 8'h61;
  localparam logic [7:0] ASCII_LC_HI = 8'h7A;
  localparam logic [7:0] CASE_DELTA  = 8'h20;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2
  } state_t;

  function automatic logic [7:0] case_swap(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b >= ASCII_UP_LO && b <= ASCII_UP_HI)
      r = b + CASE_DELTA;
    else if (b >= ASCII_LC_LO && b <= ASCII_LC_HI)
      r = b - CASE_DELTA;
    return r;
  endfunction

endpackage

// File: rtl/naive_byte_decoder.sv
// Combinational byte decoder: swaps ASCII letter case when SWAP_CASE=1.
// Ports: raw (in, 8) byte to decode; dec (out, 8) decoded byte.
module naive_byte_decoder
  import naive_codec_pkg::*;
#(
  parameter bit SWAP_CASE = 1'b1
) (
  input  logic [7:0] raw,
  output logic [7:0] dec
);

  generate
    if (SWAP_CASE) begin : g_swap
      assign dec = case_swap(raw);
    end else begin : g_pass
      assign dec = raw;
    end
  endgenerate

endmodule

// File: rtl/naive_decompressor.sv
// Splits 16-bit AXI-Stream words into bytes (LSB first), undoes the case
// swap and emits a byte-wide AXI-Stream; counts packets, flags null-last words.
// Ports: ACLK/ARESET clock and async active-high reset; S_AXIS_* 16-bit
// slave stream; M_AXIS_* 8-bit master stream; pkt_count packets sent;
// err_null_last sticky flag for TLAST on a TKEEP=00 word.
module naive_decompressor
  import naive_codec_pkg::*;
#(
  parameter bit SWAP_CASE = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [15:0]      S_AXIS_TDATA,
  input  logic [1:0]       S_AXIS_TKEEP,
  input  logic             S_AXIS_TLAST,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  output logic [7:0]       M_AXIS_TDATA,
  output logic             M_AXIS_TKEEP,
  output logic             M_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [CNT_W-1:0] pkt_count,
  output logic             err_null_last
);

  state_t           state_q;
  logic [15:0]      word_q;
  logic [1:0]       pend_q;
  logic             last_q;
  logic [CNT_W-1:0] pkt_q;
  logic             err_q;

  logic             is_final;
  logic             m_fire;
  logic             s_fire;
  logic [7:0]       cur_raw;

  // The byte on the output is the last one of the held word.
  assign is_final = (state_q == HI) ||
                    (state_q == LO && !pend_q[1]);

  assign M_AXIS_TVALID = (state_q != EMPTY);
  assign M_AXIS_TLAST  = last_q && is_final;
  assign M_AXIS_TKEEP  = 1'b1;

  assign m_fire = M_AXIS_TVALID && M_AXIS_TREADY;

  // Accept a new word while idle, or on the edge the final byte leaves,
  // so a stream of full words runs at one byte per cycle.
  assign S_AXIS_TREADY = (state_q == EMPTY) || (m_fire && is_final);
  assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;

  assign cur_raw = pend_q[0] ? word_q[7:0] : word_q[15:8];

  naive_byte_decoder #(
    .SWAP_CASE(SWAP_CASE)
  ) u_dec (
    .raw(cur_raw),
    .dec(M_AXIS_TDATA)
  );

  assign pkt_count     = pkt_q;
  assign err_null_last = err_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= EMPTY;
      word_q  <= '0;
      pend_q  <= '0;
      last_q  <= 1'b0;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (m_fire && M_AXIS_TLAST)
        pkt_q <= pkt_q + CNT_W'(1);

      if (s_fire) begin
        word_q <= S_AXIS_TDATA;
        pend_q <= S_AXIS_TKEEP;
        last_q <= S_AXIS_TLAST;
        if (S_AXIS_TKEEP == 2'b00 && S_AXIS_TLAST)
          err_q <= 1'b1;
        if (S_AXIS_TKEEP[0])
          state_q <= LO;
        else if (S_AXIS_TKEEP[1])
          state_q <= HI;
        else
          state_q <= EMPTY;
      end else if (m_fire) begin
        unique case (state_q)
          LO: begin
            pend_q[0] <= 1'b0;
            state_q   <= pend_q[1] ? HI : EMPTY;
          end
          HI: begin
            pend_q  <= 2'b00;
            state_q <= EMPTY;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_naive_decompressor.sv
// Directed testbench for naive_decompressor with a byte scoreboard.
// Expected bytes are queued when words are offered and checked on output.
module tb_naive_decompressor;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] S_AXIS_TDATA;
  logic [1:0]  S_AXIS_TKEEP;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic [7:0]  M_AXIS_TDATA;
  logic        M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [15:0] pkt_count;
  logic        err_null_last;

  always #5 ACLK = ~ACLK;

  naive_decompressor #(
    .SWAP_CASE(1'b1),
    .CNT_W(16)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TKEEP(S_AXIS_TKEEP),
    .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .pkt_count(pkt_count),
    .err_null_last(err_null_last)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sbq[$];
  int    fire_cyc[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    exp_pkt  = 0;

  always @(posedge ACLK) cyc++;

  function automatic logic [7:0] ref_dec(input logic [7:0] b);
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
      return b ^ 8'h20;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a beat transfers on the next rising edge.
  always @(negedge ACLK) begin
    beat_t e;
    if (ARESET === 1'b0 && M_AXIS_TVALID === 1'b1 &&
        M_AXIS_TREADY === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_beat", {24'h0, M_AXIS_TDATA}, 32'hFFFF);
      end else begin
        e = sbq.pop_front();
        chk("beat_data", {24'h0, M_AXIS_TDATA}, {24'h0, e.data});
        chk("beat_last", {31'h0, M_AXIS_TLAST}, {31'h0, e.last});
        if (e.last) exp_pkt++;
        fire_cyc.push_back(cyc);
      end
    end
  end

  task automatic offer(input logic [15:0] w, input logic [1:0] k,
                       input logic l);
    beat_t b;
    S_AXIS_TDATA  = w;
    S_AXIS_TKEEP  = k;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    if (k[0]) begin
      b.data = ref_dec(w[7:0]);
      b.last = l && !k[1];
      sbq.push_back(b);
    end
    if (k[1]) begin
      b.data = ref_dec(w[15:8]);
      b.last = l;
      sbq.push_back(b);
    end
  endtask

  task automatic wait_accept(input string tag);
    logic r;
    bit   done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      r = S_AXIS_TREADY;
      @(posedge ACLK);
      #1;
      if (r) begin
        done = 1'b1;
        break;
      end
    end
    S_AXIS_TVALID = 1'b0;
    if (!done) chk({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0) break;
      @(posedge ACLK);
      #1;
    end
    chk({tag, "_drain"}, sbq.size(), 0);
  endtask

  initial begin
    ARESET        = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TKEEP  = '0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;
    #12;
    chk("rst_s_ready", {31'h0, S_AXIS_TREADY}, 1);
    chk("rst_m_valid", {31'h0, M_AXIS_TVALID}, 0);
    chk("rst_m_data", {24'h0, M_AXIS_TDATA}, 0);
    chk("rst_m_last", {31'h0, M_AXIS_TLAST}, 0);
    chk("rst_pkt", {16'h0, pkt_count}, 0);
    chk("rst_err", {31'h0, err_null_last}, 0);
    chk("m_keep", {31'h0, M_AXIS_TKEEP}, 1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // 1: single two-byte packet, one-cycle latency, ready drops while busy
    offer(16'h6241, 2'b11, 1'b1);
    wait_accept("t1");
    chk("t1_latency_valid", {31'h0, M_AXIS_TVALID}, 1);
    chk("t1_latency_data", {24'h0, M_AXIS_TDATA}, 32'h61);
    chk("t1_busy_s_ready", {31'h0, S_AXIS_TREADY}, 0);
    wait_drain("t1");
    chk("t1_pkt", {16'h0, pkt_count}, 1);
    chk("t1_pkt_model", {16'h0, pkt_count}, exp_pkt);

    // 2: back-to-back words stream one byte per cycle
    fire_cyc.delete();
    offer(16'h4142, 2'b11, 1'b0);
    wait_accept("t2a");
    offer(16'h6364, 2'b11, 1'b0);
    wait_accept("t2b");
    offer(16'h2131, 2'b11, 1'b1);
    wait_accept("t2c");
    wait_drain("t2");
    chk("t2_beats", fire_cyc.size(), 6);
    if (fire_cyc.size() == 6)
      chk("t2_span", fire_cyc[5] - fire_cyc[0], 5);
    chk("t2_pkt", {16'h0, pkt_count}, exp_pkt);

    // 3: partial keeps
    offer(16'h007A, 2'b01, 1'b0);
    wait_accept("t3a");
    offer(16'h3100, 2'b10, 1'b1);
    wait_accept("t3b");
    wait_drain("t3");
    chk("t3_pkt", {16'h0, pkt_count}, exp_pkt);

    // 4: backpressure holds the output and the next word waits
    M_AXIS_TREADY = 1'b0;
    offer(16'h4241, 2'b11, 1'b0);
    wait_accept("t4a");
    offer(16'h0A43, 2'b11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t4_hold_data", {24'h0, M_AXIS_TDATA}, 32'h61);
      chk("t4_hold_last", {31'h0, M_AXIS_TLAST}, 0);
      chk("t4_hold_valid", {31'h0, M_AXIS_TVALID}, 1);
      chk("t4_hold_s_ready", {31'h0, S_AXIS_TREADY}, 0);
    end
    @(posedge ACLK);
    #1;
    M_AXIS_TREADY = 1'b1;
    wait_accept("t4b");
    wait_drain("t4");
    chk("t4_pkt", {16'h0, pkt_count}, exp_pkt);

    // 5: null word with TLAST is dropped and flagged
    offer(16'h4142, 2'b00, 1'b1);
    wait_accept("t5a");
    repeat (3) @(posedge ACLK);
    #1;
    chk("t5_err", {31'h0, err_null_last}, 1);
    chk("t5_no_beat", {31'h0, M_AXIS_TVALID}, 0);
    chk("t5_pkt", {16'h0, pkt_count}, exp_pkt);
    offer(16'h5A7A, 2'b11, 1'b1);
    wait_accept("t5b");
    wait_drain("t5");
    chk("t5_err_sticky", {31'h0, err_null_last}, 1);
    chk("t5_pkt_after", {16'h0, pkt_count}, exp_pkt);

    // 6: asynchronous reset mid-word discards pending bytes
    M_AXIS_TREADY = 1'b0;
    offer(16'h6241, 2'b11, 1'b1);
    wait_accept("t6a");
    @(posedge ACLK);
    #3;
    ARESET = 1'b1;
    #1;
    chk("t6_async_valid", {31'h0, M_AXIS_TVALID}, 0);
    chk("t6_async_s_ready", {31'h0, S_AXIS_TREADY}, 1);
    chk("t6_async_pkt", {16'h0, pkt_count}, 0);
    chk("t6_async_err", {31'h0, err_null_last}, 0);
    sbq.delete();
    exp_pkt = 0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    M_AXIS_TREADY = 1'b1;
    offer(16'h2161, 2'b11, 1'b1);
    wait_accept("t6b");
    wait_drain("t6");
    chk("t6_pkt", {16'h0, pkt_count}, 1);

    repeat (2) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
